// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches variable-length (1 or 2 byte) instructions from a
//               128x8 program ROM with combinational read, and presents each
//               instruction to the decoder as a single bundle through a
//               valid/ready handshake. A redirect reloads the PC and discards
//               any fetch in progress or any bundle still pending.
// Ports       : clk            rising-edge clock
//               reset          synchronous active-high reset
//               rom_addr       ROM address (always equal to the PC)
//               rom_data       ROM read data for rom_addr, same cycle
//               redirect       load PC from redirect_addr (highest priority)
//               redirect_addr  new PC value
//               instr_valid    bundle available
//               instr_ready    decoder accepts bundle
//               instr_opcode   opcode byte
//               instr_operand  operand byte, 8'h00 for 1-byte instructions
//               instr_len      0 = 1-byte, 1 = 2-byte instruction
//               instr_pc       address of the opcode byte
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [6:0] RESET_VECTOR = 7'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       redirect,
  input  logic [6:0] redirect_addr,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_operand,
  output logic       instr_len,
  output logic [6:0] instr_pc
);

  localparam logic [1:0] S_OPCODE  = 2'd0;
  localparam logic [1:0] S_OPERAND = 2'd1;
  localparam logic [1:0] S_VALID   = 2'd2;

  logic [1:0] r_state;
  logic [6:0] r_pc;
  logic       r_valid;
  logic [7:0] r_opcode;
  logic [7:0] r_operand;
  logic       r_len;
  logic [6:0] r_instr_pc;

  logic       w_one_byte;
  logic [6:0] w_pc_next;

  // Opcodes 00-1F and 40-5F are single byte: top three bits 000 or 010.
  assign w_one_byte = (rom_data[7:5] == 3'b000) || (rom_data[7:5] == 3'b010);

  // 7-bit add wraps naturally from 7F to 00.
  assign w_pc_next  = r_pc + 7'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_OPCODE;
      r_pc       <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_opcode   <= 8'h00;
      r_operand  <= 8'h00;
      r_len      <= 1'b0;
      r_instr_pc <= 7'h00;
    end else if (redirect) begin
      // Drops any partial fetch and any pending bundle (accepted or not).
      r_state <= S_OPCODE;
      r_pc    <= redirect_addr;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_OPCODE: begin
          r_opcode   <= rom_data;
          r_instr_pc <= r_pc;
          r_pc       <= w_pc_next;
          if (w_one_byte) begin
            r_operand <= 8'h00;
            r_len     <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= S_VALID;
          end else begin
            r_len   <= 1'b1;
            r_state <= S_OPERAND;
          end
        end
        S_OPERAND: begin
          r_operand <= rom_data;
          r_pc      <= w_pc_next;
          r_valid   <= 1'b1;
          r_state   <= S_VALID;
        end
        S_VALID: begin
          // Bundle registers and PC hold until the decoder takes the bundle.
          if (instr_ready) begin
            r_valid <= 1'b0;
            r_state <= S_OPCODE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_OPCODE;
        end
      endcase
    end
  end

  assign rom_addr      = r_pc;
  assign instr_valid   = r_valid;
  assign instr_opcode  = r_opcode;
  assign instr_operand = r_operand;
  assign instr_len     = r_len;
  assign instr_pc      = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit using the
//               ROM image 86 AA 96 F0 20 FE followed by zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic [6:0] rom_addr;
  logic [7:0] rom_data;
  logic       redirect;
  logic [6:0] redirect_addr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic       instr_len;
  logic [6:0] instr_pc;

  logic [7:0] rom [0:127];

  int n_total;
  int n_pass;

  // Full observable state: valid, opcode, operand, len, pc, rom_addr
  logic [31:0] obs;
  logic [7:0]  vaddr;
  logic [31:0] held;

  assign rom_data = rom[rom_addr];
  assign obs      = {instr_valid, instr_opcode, instr_operand, instr_len, instr_pc, rom_addr};
  assign vaddr    = {instr_valid, rom_addr};

  instr_fetch_unit #(.RESET_VECTOR(7'h00)) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_len     (instr_len),
    .instr_pc      (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b1; redirect_addr = 7'h33; instr_ready = 1'b1;
    step();
    step();
    n_total++;
    if (obs !== {1'b0, 8'h00, 8'h00, 1'b0, 7'h00, 7'h00})
      $display("FAIL reset_state: got %h want %h", obs, {1'b0, 8'h00, 8'h00, 1'b0, 7'h00, 7'h00});
    else n_pass++;
  endtask

  task automatic test_sequential();
    reset = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
    step();
    n_total++;
    if (vaddr !== {1'b0, 7'h01})
      $display("FAIL seq_operand_phase: got %h want %h", vaddr, {1'b0, 7'h01});
    else n_pass++;
    step();
    n_total++;
    if (obs !== {1'b1, 8'h86, 8'hAA, 1'b1, 7'h00, 7'h02})
      $display("FAIL seq_bundle0: got %h want %h", obs, {1'b1, 8'h86, 8'hAA, 1'b1, 7'h00, 7'h02});
    else n_pass++;
    step();
    n_total++;
    if (vaddr !== {1'b0, 7'h02})
      $display("FAIL seq_accept0: got %h want %h", vaddr, {1'b0, 7'h02});
    else n_pass++;
    step(); step();
    n_total++;
    if (obs !== {1'b1, 8'h96, 8'hF0, 1'b1, 7'h02, 7'h04})
      $display("FAIL seq_bundle1: got %h want %h", obs, {1'b1, 8'h96, 8'hF0, 1'b1, 7'h02, 7'h04});
    else n_pass++;
    step(); step();
    instr_ready = 1'b0;
    step();
    n_total++;
    if (obs !== {1'b1, 8'h20, 8'hFE, 1'b1, 7'h04, 7'h06})
      $display("FAIL seq_bundle2: got %h want %h", obs, {1'b1, 8'h20, 8'hFE, 1'b1, 7'h04, 7'h06});
    else n_pass++;
  endtask

  task automatic test_stall();
    held = {1'b1, 8'h20, 8'hFE, 1'b1, 7'h04, 7'h06};
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++;
      if (obs !== held)
        $display("FAIL stall_hold cycle %0d: got %h want %h", i, obs, held);
      else n_pass++;
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    n_total++;
    if (obs !== {1'b0, 8'h20, 8'hFE, 1'b1, 7'h04, 7'h06})
      $display("FAIL stall_single_accept: got %h want %h", obs, {1'b0, 8'h20, 8'hFE, 1'b1, 7'h04, 7'h06});
    else n_pass++;
    step();
    n_total++;
    if (obs !== {1'b1, 8'h00, 8'h00, 1'b0, 7'h06, 7'h07})
      $display("FAIL stall_next_bundle: got %h want %h", obs, {1'b1, 8'h00, 8'h00, 1'b0, 7'h06, 7'h07});
    else n_pass++;
    step();
    n_total++;
    if (obs !== {1'b1, 8'h00, 8'h00, 1'b0, 7'h06, 7'h07})
      $display("FAIL stall_no_double: got %h want %h", obs, {1'b1, 8'h00, 8'h00, 1'b0, 7'h06, 7'h07});
    else n_pass++;
  endtask

  task automatic test_redirect_1byte();
    // Bundle at pc 06 pending with instr_ready=0: redirect drops it.
    redirect = 1'b1; redirect_addr = 7'h0A;
    step();
    redirect = 1'b0;
    n_total++;
    if (vaddr !== {1'b0, 7'h0A})
      $display("FAIL redir_drop: got %h want %h", vaddr, {1'b0, 7'h0A});
    else n_pass++;
    step();
    n_total++;
    if (obs !== {1'b1, 8'h4F, 8'h00, 1'b0, 7'h0A, 7'h0B})
      $display("FAIL redir_1byte: got %h want %h", obs, {1'b1, 8'h4F, 8'h00, 1'b0, 7'h0A, 7'h0B});
    else n_pass++;
  endtask

  task automatic test_redirect_with_accept();
    instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 7'h0A;
    step();
    redirect = 1'b0; instr_ready = 1'b0;
    n_total++;
    if (vaddr !== {1'b0, 7'h0A})
      $display("FAIL redir_accept_same_edge: got %h want %h", vaddr, {1'b0, 7'h0A});
    else n_pass++;
    step();
    n_total++;
    if (obs !== {1'b1, 8'h4F, 8'h00, 1'b0, 7'h0A, 7'h0B})
      $display("FAIL redir_accept_refetch: got %h want %h", obs, {1'b1, 8'h4F, 8'h00, 1'b0, 7'h0A, 7'h0B});
    else n_pass++;
  endtask

  task automatic test_wrap();
    rom[127] = 8'h86;
    rom[0]   = 8'h11;
    redirect = 1'b1; redirect_addr = 7'h7F;
    step();
    redirect = 1'b0;
    n_total++;
    if (vaddr !== {1'b0, 7'h7F})
      $display("FAIL wrap_redirect: got %h want %h", vaddr, {1'b0, 7'h7F});
    else n_pass++;
    step();
    n_total++;
    if (vaddr !== {1'b0, 7'h00})
      $display("FAIL wrap_pc_rollover: got %h want %h", vaddr, {1'b0, 7'h00});
    else n_pass++;
    step();
    n_total++;
    if (obs !== {1'b1, 8'h86, 8'h11, 1'b1, 7'h7F, 7'h01})
      $display("FAIL wrap_bundle: got %h want %h", obs, {1'b1, 8'h86, 8'h11, 1'b1, 7'h7F, 7'h01});
    else n_pass++;
    rom[0] = 8'h86;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_operand();
    // Now in S_OPCODE at 01 (AA, 2-byte); this edge moves to S_OPERAND.
    step();
    n_total++;
    if (vaddr !== {1'b0, 7'h02})
      $display("FAIL partial_in_operand: got %h want %h", vaddr, {1'b0, 7'h02});
    else n_pass++;
    redirect = 1'b1; redirect_addr = 7'h04;
    step();
    redirect = 1'b0;
    n_total++;
    if (vaddr !== {1'b0, 7'h04})
      $display("FAIL partial_discard: got %h want %h", vaddr, {1'b0, 7'h04});
    else n_pass++;
    step();
    n_total++;
    if (vaddr !== {1'b0, 7'h05})
      $display("FAIL partial_no_bundle: got %h want %h", vaddr, {1'b0, 7'h05});
    else n_pass++;
    step();
    n_total++;
    if (obs !== {1'b1, 8'h20, 8'hFE, 1'b1, 7'h04, 7'h06})
      $display("FAIL partial_new_bundle: got %h want %h", obs, {1'b1, 8'h20, 8'hFE, 1'b1, 7'h04, 7'h06});
    else n_pass++;
  endtask

  task automatic test_reset_pending();
    reset = 1'b1; redirect = 1'b1; redirect_addr = 7'h10; instr_ready = 1'b1;
    step();
    reset = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    n_total++;
    if (obs !== {1'b0, 8'h00, 8'h00, 1'b0, 7'h00, 7'h00})
      $display("FAIL rst_pending_clear: got %h want %h", obs, {1'b0, 8'h00, 8'h00, 1'b0, 7'h00, 7'h00});
    else n_pass++;
    step();
    step();
    n_total++;
    if (obs !== {1'b1, 8'h86, 8'hAA, 1'b1, 7'h00, 7'h02})
      $display("FAIL rst_restart_bundle: got %h want %h", obs, {1'b1, 8'h86, 8'hAA, 1'b1, 7'h00, 7'h02});
    else n_pass++;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    rom[0] = 8'h86; rom[1] = 8'hAA; rom[2] = 8'h96;
    rom[3] = 8'hF0; rom[4] = 8'h20; rom[5] = 8'hFE;
    rom[10] = 8'h4F;
    reset = 1'b1; redirect = 1'b0; redirect_addr = 7'h00; instr_ready = 1'b0;

    test_reset();
    test_sequential();
    test_stall();
    test_redirect_1byte();
    test_redirect_with_accept();
    test_wrap();
    test_redirect_operand();
    test_reset_pending();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
